// File: rtl/rr_bus_pkg.sv
// Shared constants, state encodings and helpers for the round-robin bus mux.
package rr_bus_pkg;

  localparam int DEF_BUS_WIDTH = 16;
  localparam int DEF_NUM_CH    = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter
  import rr_bus_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int SEL_W = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < NUM_CH; k++) begin
        // NUM_CH is a power of two, so the index wraps in SEL_W bits
        idx = ptr + SEL_W'(k);
        if (!any_grant && req[idx]) begin
          any_grant = 1'b1;
          grant_idx = idx;
        end
      end
      if (any_grant) grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// Registered N:1 round-robin bus mux with valid/ready handshakes.
// Define RR_BUS_MUX_LOCK_EN to add in_last/out_last packet locking.
module rr_bus_mux
  import rr_bus_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH,
  localparam int SEL_W    = clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
`ifdef RR_BUS_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]           in_last,
  output logic                        out_last,
`endif
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  state_t           st_q, st_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] gidx;
  logic [NUM_CH-1:0] req;
  logic             any_grant;
  logic             load_ok;

  assign out_valid = (st_q == ST_FULL);
  assign load_ok   = !out_valid || out_ready;

`ifdef RR_BUS_MUX_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch;

  // While locked only the owning channel may compete
  always_comb begin
    req = in_valid;
    if (lock_q) req = in_valid & (NUM_CH'(1) << lock_ch);
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .enable    (load_ok && !reset),
    .grant     (in_ready),
    .grant_idx (gidx),
    .any_grant (any_grant)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_EMPTY: if (any_grant) st_d = ST_FULL;
      ST_FULL: begin
        if (any_grant)      st_d = ST_FULL;
        else if (out_ready) st_d = ST_EMPTY;
      end
      default: st_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
`ifdef RR_BUS_MUX_LOCK_EN
      lock_q   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      if (any_grant) begin
        out_data <= in_data[gidx*BUS_WIDTH +: BUS_WIDTH];
        out_sel  <= gidx;
`ifdef RR_BUS_MUX_LOCK_EN
        out_last <= in_last[gidx];
        lock_q   <= !in_last[gidx];
        lock_ch  <= gidx;
        if (in_last[gidx]) ptr_q <= gidx + SEL_W'(1);
`else
        ptr_q    <= gidx + SEL_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed self-checking bench for rr_bus_mux (NUM_CH=4, BUS_WIDTH=16).
module tb_rr_bus_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef RR_BUS_MUX_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_bus_mux #(
    .BUS_WIDTH (16),
    .NUM_CH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_BUS_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [15:0] v);
    in_data[i*16 +: 16] = v;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] sel,
                            input logic [15:0] data);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
    chk({tag, "_data"}, 32'(out_data), 32'(data));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
`ifdef RR_BUS_MUX_LOCK_EN
    in_last   = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) set_ch(i, 16'h1000 + 16'(i));
    #1;
    chk("rst_ready_now", 32'(in_ready), 32'd0);
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);

    // round robin with every channel requesting
    reset = 1'b0;
    #1;
    chk("first_ready", 32'(in_ready), 32'b0001);
    step(); expect_out("rr0", 2'd0, 16'h1000);
    step(); expect_out("rr1", 2'd1, 16'h1001);
    step(); expect_out("rr2", 2'd2, 16'h1002);
    step(); expect_out("rr3", 2'd3, 16'h1003);
    step(); expect_out("rr4", 2'd0, 16'h1000);

    // drain without a new grant, data and sel hold; ptr is now 1
    in_valid = 4'b0000;
    step();
    chk("drain_v", 32'(out_valid), 32'd0);
    chk("drain_sel", 32'(out_sel), 32'd0);
    chk("drain_data", 32'(out_data), 32'h1000);

    // backpressure
    set_ch(1, 16'hA5A5);
    in_valid = 4'b0010;
    step(); expect_out("bp_load", 2'd1, 16'hA5A5);
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      step();
      expect_out("bp_hold", 2'd1, 16'hA5A5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    step(); expect_out("bp_next", 2'd2, 16'h1002);

    // sparse / wrap: ptr is 3, only ch1 requests
    set_ch(1, 16'h1001);
    in_valid = 4'b0010;
    step(); expect_out("wrap_ch1", 2'd1, 16'h1001);
    in_valid = 4'b1001;
    step(); expect_out("wrap_ch3", 2'd3, 16'h1003);
    step(); expect_out("wrap_ch0", 2'd0, 16'h1000);

    // lone requester is granted every cycle
    in_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step(); expect_out("lone", 2'd2, 16'h1002);
    end

    // in_valid dropping under backpressure changes nothing
    out_ready = 1'b0;
    in_valid  = 4'b1011;
    #1;
    chk("drop_ready", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    step(); expect_out("drop_hold", 2'd2, 16'h1002);

    // reset while holding a stalled word
    reset = 1'b1;
    step();
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    #1;
    chk("mid_rst_ptr", 32'(in_ready), 32'b0001);
    step(); expect_out("post_rst", 2'd0, 16'h1000);

`ifdef RR_BUS_MUX_LOCK_EN
    // ptr=1: ch1 sends a 3-word packet while ch0 and ch2 request
    in_valid = 4'b0000;
    step();
    in_valid = 4'b0111;
    in_last  = 4'b0000;
    step(); expect_out("lock0", 2'd1, 16'h1001);
    chk("lock0_last", 32'(out_last), 32'd0);
    step(); expect_out("lock1", 2'd1, 16'h1001);
    in_last = 4'b0010;
    step(); expect_out("lock2", 2'd1, 16'h1001);
    chk("lock2_last", 32'(out_last), 32'd1);
    in_last = 4'b1111;
    step(); expect_out("lock_free", 2'd2, 16'h1002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
